// File: rtl/mem_port_arbiter.sv
// ============================================================================
//  Module   : mem_port_arbiter
//  Purpose  : Shares one memory port between fetch (I) and memory-stage (D)
//             requesters; D has priority, bounded by a streak limit.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_port_arbiter #(
    parameter int MAX_D_STREAK = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic [31:0] i_rdata,
    output logic        i_ready,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [3:0]  d_be,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic [31:0] d_rdata,
    output logic        d_ready,
    output logic        mem_req,
    output logic        mem_we,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack
);

    localparam logic [3:0] C_STREAK_LIMIT = 4'(MAX_D_STREAK);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERVE_I = 2'd1,
        SERVE_D = 2'd2,
        RESP    = 2'd3
    } state_t;

    state_t      state_q,     state_d;
    logic [3:0]  streak_q,    streak_d;
    logic        mem_req_q,   mem_req_d;
    logic        mem_we_q,    mem_we_d;
    logic [3:0]  mem_be_q,    mem_be_d;
    logic [31:0] mem_addr_q,  mem_addr_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic [31:0] i_rdata_q,   i_rdata_d;
    logic [31:0] d_rdata_q,   d_rdata_d;
    logic        i_ready_q,   i_ready_d;
    logic        d_ready_q,   d_ready_d;

    logic        w_grant_d;

    // D wins unless fetch is waiting and D has already used up its streak.
    assign w_grant_d = d_req && !(i_req && (streak_q == C_STREAK_LIMIT));

    always_comb begin
        state_d     = state_q;
        streak_d    = streak_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_be_d    = mem_be_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        i_rdata_d   = i_rdata_q;
        d_rdata_d   = d_rdata_q;
        i_ready_d   = 1'b0;
        d_ready_d   = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (w_grant_d) begin
                    state_d     = SERVE_D;
                    mem_req_d   = 1'b1;
                    mem_we_d    = d_we;
                    mem_be_d    = d_be;
                    mem_addr_d  = d_addr;
                    mem_wdata_d = d_wdata;
                    streak_d    = i_req ? (streak_q + 4'd1) : 4'd0;
                end else if (i_req) begin
                    state_d     = SERVE_I;
                    mem_req_d   = 1'b1;
                    mem_we_d    = 1'b0;
                    mem_be_d    = 4'hF;
                    mem_addr_d  = i_addr;
                    mem_wdata_d = 32'd0;
                    streak_d    = 4'd0;
                end
            end
            SERVE_I: begin
                if (mem_ack) begin
                    i_rdata_d = mem_rdata;
                    i_ready_d = 1'b1;
                    mem_req_d = 1'b0;
                    state_d   = RESP;
                end
            end
            SERVE_D: begin
                if (mem_ack) begin
                    if (!mem_we_q) begin
                        d_rdata_d = mem_rdata;
                    end
                    d_ready_d = 1'b1;
                    mem_req_d = 1'b0;
                    state_d   = RESP;
                end
            end
            RESP: begin
                // The ready pulse is already on the outputs during this cycle.
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            streak_q    <= 4'd0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_be_q    <= 4'd0;
            mem_addr_q  <= 32'd0;
            mem_wdata_q <= 32'd0;
            i_rdata_q   <= 32'd0;
            d_rdata_q   <= 32'd0;
            i_ready_q   <= 1'b0;
            d_ready_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            streak_q    <= streak_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_be_q    <= mem_be_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            i_rdata_q   <= i_rdata_d;
            d_rdata_q   <= d_rdata_d;
            i_ready_q   <= i_ready_d;
            d_ready_q   <= d_ready_d;
        end
    end

    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_be    = mem_be_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign i_rdata   = i_rdata_q;
    assign d_rdata   = d_rdata_q;
    assign i_ready   = i_ready_q;
    assign d_ready   = d_ready_q;

endmodule

`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
// ============================================================================
//  Module   : tb_mem_port_arbiter
//  Purpose  : Self-checking bench for mem_port_arbiter, directed + random.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_port_arbiter;

    localparam int C_MAX_D_STREAK = 4;

    logic        clock = 1'b0;
    logic        reset;
    logic        i_req, d_req, d_we, mem_ack;
    logic [3:0]  d_be;
    logic [31:0] i_addr, d_addr, d_wdata, mem_rdata;
    logic [31:0] i_rdata, d_rdata, mem_addr, mem_wdata;
    logic        i_ready, d_ready, mem_req, mem_we;
    logic [3:0]  mem_be;

    int          n_checks = 0;
    int          n_errors = 0;

    // Transaction-level reference state
    int          m_streak;
    logic [31:0] m_i_rdata, m_d_rdata;

    mem_port_arbiter #(.MAX_D_STREAK(C_MAX_D_STREAK)) dut (
        .clock(clock), .reset(reset),
        .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_ready(i_ready),
        .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr),
        .d_wdata(d_wdata), .d_rdata(d_rdata), .d_ready(d_ready),
        .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic model_reset;
        m_streak  = 0;
        m_i_rdata = 32'd0;
        m_d_rdata = 32'd0;
    endtask

    // Called during an IDLE cycle with payloads already on the inputs.
    task automatic access(input bit ireq, input bit dreq, input int k,
                          input logic [31:0] rd, input bit junk, output bit gi);
        logic [31:0] e_addr, e_wdata;
        logic        e_we;
        logic [3:0]  e_be;
        i_req     = ireq;
        d_req     = dreq;
        mem_ack   = junk ? 1'($urandom_range(0, 1)) : 1'b0;
        mem_rdata = $urandom;
        gi        = 1'b0;
        if (!ireq && !dreq) begin
            tick;
            mem_ack = 1'b0;
            check("noreq_mem_req", {31'd0, mem_req}, 32'd0);
            return;
        end
        gi      = (ireq && dreq) ? (m_streak == C_MAX_D_STREAK) : ireq;
        e_addr  = gi ? i_addr : d_addr;
        e_we    = gi ? 1'b0 : d_we;
        e_be    = gi ? 4'hF : d_be;
        e_wdata = d_wdata;
        m_streak = (gi || !ireq) ? 0 : m_streak + 1;

        tick;
        mem_ack = 1'b0;
        for (int j = 0; j < k; j++) begin
            check("serve_mem_req", {31'd0, mem_req}, 32'd1);
            check("serve_mem_addr", mem_addr, e_addr);
            check("serve_mem_we", {31'd0, mem_we}, {31'd0, e_we});
            check("serve_mem_be", {28'd0, mem_be}, {28'd0, e_be});
            if (!gi) check("serve_mem_wdata", mem_wdata, e_wdata);
            check("serve_readys", {30'd0, i_ready, d_ready}, 32'd0);
            if (junk) begin
                i_addr  = $urandom;
                d_addr  = $urandom;
                d_wdata = $urandom;
                d_be    = 4'($urandom);
                d_we    = 1'($urandom_range(0, 1));
            end
            if (j == k - 1) begin
                mem_ack   = 1'b1;
                mem_rdata = rd;
            end
            tick;
            mem_ack   = 1'b0;
            mem_rdata = $urandom;
        end

        if (gi) m_i_rdata = rd;
        else if (!e_we) m_d_rdata = rd;
        check("resp_mem_req", {31'd0, mem_req}, 32'd0);
        check("resp_i_ready", {31'd0, i_ready}, {31'd0, gi});
        check("resp_d_ready", {31'd0, d_ready}, {31'd0, !gi});
        check("resp_i_rdata", i_rdata, m_i_rdata);
        check("resp_d_rdata", d_rdata, m_d_rdata);

        if (junk) begin
            mem_ack = 1'($urandom_range(0, 1));
            i_req   = 1'($urandom_range(0, 1));
            d_req   = 1'($urandom_range(0, 1));
        end
        tick;
        mem_ack = 1'b0;
        check("idle_readys", {30'd0, i_ready, d_ready}, 32'd0);
        check("idle_mem_req", {31'd0, mem_req}, 32'd0);
        check("idle_i_rdata", i_rdata, m_i_rdata);
        check("idle_d_rdata", d_rdata, m_d_rdata);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit          gi;
        logic [31:0] saved;
        int          r;

        reset = 1'b1;
        i_req = 0; d_req = 0; d_we = 0; d_be = 0; mem_ack = 0;
        i_addr = 0; d_addr = 0; d_wdata = 0; mem_rdata = 0;
        model_reset();
        tick;
        tick;

        // Reset asserted mid-cycle: outputs clear without waiting for an edge.
        #3 reset = 1'b0;
        #1;
        check("rst_mem_req", {31'd0, mem_req}, 32'd0);
        check("rst_mem_we", {31'd0, mem_we}, 32'd0);
        check("rst_mem_be", {28'd0, mem_be}, 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
        check("rst_mem_wdata", mem_wdata, 32'd0);
        check("rst_i_rdata", i_rdata, 32'd0);
        check("rst_d_rdata", d_rdata, 32'd0);
        check("rst_readys", {30'd0, i_ready, d_ready}, 32'd0);
        tick;
        tick;
        #3 reset = 1'b1;
        for (int c = 0; c < 10; c++) begin
            tick;
            check("idle_no_req", {31'd0, mem_req}, 32'd0);
        end

        // Zero-wait fetch
        i_addr = 32'h0040_0000;
        access(1'b1, 1'b0, 1, 32'h8C08_0004, 1'b0, gi);
        check("fetch_granted_i", {31'd0, gi}, 32'd1);
        check("fetch_i_rdata", i_rdata, 32'h8C08_0004);

        // Simultaneous requests: D first, then I in the next IDLE cycle
        i_addr = 32'h0040_0004; d_addr = 32'h1001_0000; d_we = 1'b0; d_be = 4'hF;
        access(1'b1, 1'b1, 1, 32'h1234_5678, 1'b0, gi);
        check("simul_first_d", {31'd0, gi}, 32'd0);
        access(1'b1, 1'b0, 2, 32'h0000_0013, 1'b0, gi);
        check("simul_then_i", {31'd0, gi}, 32'd1);

        // Starvation limit: four D grants, then one I grant, repeating
        for (int n = 0; n < 15; n++) begin
            d_addr = 32'h1001_0000 + 32'(4 * n);
            i_addr = 32'h0040_0100 + 32'(4 * n);
            access(1'b1, 1'b1, 1 + (n % 2), $urandom, 1'b0, gi);
            check("streak_pattern", {31'd0, gi}, {31'd0, (n % 5) == 4});
        end

        // Store with three wait cycles leaves d_rdata alone
        saved = d_rdata;
        d_we = 1'b1; d_be = 4'b0011; d_wdata = 32'hCAFE_BABE; d_addr = 32'h1001_0040;
        access(1'b0, 1'b1, 3, 32'hDEAD_0001, 1'b0, gi);
        check("store_granted_d", {31'd0, gi}, 32'd0);
        check("store_rdata_kept", d_rdata, saved);

        // Reset during SERVE_D, then a late ack
        d_we = 1'b0; d_addr = 32'h1001_0080; d_req = 1'b1; i_req = 1'b0;
        tick;
        check("abort_mem_req_on", {31'd0, mem_req}, 32'd1);
        tick;
        #2 reset = 1'b0;
        #1;
        check("abort_mem_req_off", {31'd0, mem_req}, 32'd0);
        model_reset();
        d_req = 1'b0;
        #2 reset = 1'b1;
        tick;
        mem_ack = 1'b1; mem_rdata = 32'hBAD0_BAD0;
        tick;
        mem_ack = 1'b0;
        for (int c = 0; c < 3; c++) begin
            check("late_ack_readys", {30'd0, i_ready, d_ready}, 32'd0);
            check("late_ack_mem_req", {31'd0, mem_req}, 32'd0);
            check("late_ack_d_rdata", d_rdata, 32'd0);
            check("late_ack_i_rdata", i_rdata, 32'd0);
            tick;
        end
        i_addr = 32'h0040_0200;
        access(1'b1, 1'b0, 1, 32'h0BAD_F00D, 1'b0, gi);
        check("post_abort_i", {31'd0, gi}, 32'd1);

        // Random traffic with mid-access input churn and spurious acks
        for (int t = 0; t < 150; t++) begin
            i_addr  = $urandom;
            d_addr  = $urandom;
            d_wdata = $urandom;
            d_be    = 4'($urandom);
            d_we    = 1'($urandom_range(0, 1));
            r = $urandom_range(0, 7);
            access(r < 6, (r < 4) || (r == 6), $urandom_range(1, 4), $urandom, 1'b1, gi);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Arbitrates a single shared memory port between the fetch stage (I-side) and the memory stage (D-side) of the 5-stage pipeline. Latches one request at a time, holds the memory-side request until acknowledged, and returns read data with a one-cycle ready pulse. The memory stage then forwards `d_rdata` into the memory/writeback pipeline register. D-side has priority; a streak limit prevents fetch starvation.

## Interface
- `MAX_D_STREAK`, 4: maximum consecutive D grants while `i_req` is pending before I is forced. Legal range is 1..15.
- `clock`  in  1  — single clock, rising edge.
- `reset`  in  1  — asynchronous, active-low reset.
- `i_req`  in  1  — fetch request. Held high until `i_ready`.
- `i_addr`  in  32  — fetch address.
- `i_rdata`  out  32  — fetched word (registered).
- `i_ready`  out  1  — one-cycle pulse: fetch complete, `i_rdata` valid.
- `d_req`  in  1  — data request. Held high until `d_ready`.
- `d_we`  in  1  — 1 = store, 0 = load.
- `d_be`  in  4  — store byte enables.
- `d_addr`  in  32  — data address.
- `d_wdata`  in  32  — store data.
- `d_rdata`  out  32  — load data (registered).
- `d_ready`  out  1  — one-cycle pulse: data access complete.
- `mem_req`  out  1  — memory request.
- `mem_we`  out  1  — memory write enable.
- `mem_be`  out  4  — memory byte enables.
- `mem_addr`  out  32  — memory address.
- `mem_wdata`  out  32  — memory write data.
- `mem_rdata`  in  32  — memory read data. Valid when `mem_ack` is high.
- `mem_ack`  in  1  — one-cycle completion pulse from memory.

## Operation
- FSM states: IDLE, SERVE_I, SERVE_D, RESP.
- IDLE arbitration, sampled at a clock edge:
  - Both `d_req` and `i_req` high: if streak == `MAX_D_STREAK`, grant I; else grant D.
  - Only one request high: grant that side.
  - Neither high: stay in IDLE.
- Grant actions: register address, we, be and wdata into the memory-side output registers. An I grant forces we=0 and be=4'hF. Enter SERVE_I or SERVE_D.
- Streak counter (4-bit):
  - D grant with `i_req` high: streak+1.
  - D grant with `i_req` low: streak reset to 0.
  - Any I grant: streak reset to 0.
- SERVE_x:
  - `mem_req`=1 and all memory-side outputs stay stable until `mem_ack`.
  - On `mem_ack`: a load or fetch captures `mem_rdata` into `x_rdata`. A store leaves `d_rdata` unchanged.
  - After `mem_ack`, `mem_req` drops and the FSM enters RESP.
- RESP: exactly one cycle. Pulse `i_ready` or `d_ready` for the served side, then return to IDLE. Requests are not sampled in RESP.
- Requester inputs are ignored outside IDLE. Changes to them mid-access have no effect.
- `mem_ack` is ignored in IDLE and RESP, including a late or spurious ack.
- Only one access is outstanding at any time, so `i_ready` and `d_ready` are never high together.

## Timing
- Reset (asynchronous, while `reset`=0):
  - All outputs go to 0: `mem_req`, `mem_we`, `mem_be`, `mem_addr`, `mem_wdata`, `i_rdata`, `d_rdata`, `i_ready`, `d_ready`.
  - State goes to IDLE and streak to 0.
- Reset asserted mid-access: `mem_req` drops immediately and the access is abandoned. No ready pulse is issued.
- Latency, with the request sampled in IDLE at edge 0:
  - `mem_req` is high from edge 0 onward.
  - `mem_ack` arrives k cycles later, k ≥ 1 (k=1 means ack in the first `mem_req` cycle).
  - Ready pulses for the cycle after the ack edge.
  - With zero-wait memory, request-to-ready is 2 cycles and request-to-next-grant is 3 cycles.
- Back-to-back access: a requester still holding `req` high in the cycle after its ready pulse starts a new access.
- `x_rdata` holds its value until the next completed load or fetch on that side.

## Test plan
- Reset and idle:
  - Stimulus: drive `reset` low mid-cycle, hold all requests low.
  - Required: all outputs 0 asynchronously; `mem_req` stays 0 for 10 cycles.
- Zero-wait fetch:
  - Stimulus: `i_req`=1, `i_addr`=0x00400000; memory acks in the first cycle with `mem_rdata`=0x8C080004.
  - Required: `mem_addr`=0x00400000, `mem_we`=0, `mem_be`=4'hF; `i_ready` pulses 2 cycles after the request; `i_rdata`=0x8C080004.
- Simultaneous requests:
  - Stimulus: `i_req` and `d_req` (load at 0x10010000) asserted together.
  - Required: D is served first and `d_ready` pulses; the I grant follows in the IDLE cycle after RESP.
- Starvation limit:
  - Stimulus: `i_req` held high; `d_req` re-asserted every IDLE cycle; `MAX_D_STREAK`=4.
  - Required: exactly 4 D grants, then 1 I grant, then the D pattern repeats.
- Store with wait states:
  - Stimulus: `d_we`=1, `d_be`=4'b0011, `d_wdata`=0xCAFEBABE, `mem_ack` after 3 cycles.
  - Required: memory-side outputs stable for all 3 cycles; `d_ready` pulses once; `d_rdata` unchanged.
- Reset mid-access plus late ack:
  - Stimulus: assert `reset` during SERVE_D, release it, then pulse `mem_ack`.
  - Required: no ready pulse and no rdata change; the FSM remains in IDLE.
